// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: boots, advances, redirects, stalls, flushes and halts fetch.
// Optional performance counters are enabled by defining FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
    parameter int                 ADDR_W       = 9,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter logic [15:0]        HALT_WORD    = 16'hffff,
    parameter int                 FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              do_branch,
    input  logic              do_jump,
    input  logic [ADDR_W-1:0] target,
    input  logic              fetched_valid,
    input  logic [15:0]       fetched_word,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_en,
    output logic              flush,
    output logic              halted
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } state_e;

    localparam logic [2:0]        FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PC_ONE       = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fetch_en_q, fetch_en_d;
    logic              flush_q, flush_d;
    logic              halted_q, halted_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              redirect;

    assign redirect = do_branch | do_jump;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_en_d = fetch_en_q;
        flush_d    = flush_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                fetch_en_d = 1'b1;
            end
            ST_RUN: begin
                if (redirect) begin
                    state_d    = ST_FLUSH;
                    pc_d       = target;
                    flush_d    = 1'b1;
                    fetch_en_d = 1'b0;
                    cnt_d      = FLUSH_RELOAD;
                end else if (fetched_valid && (fetched_word == HALT_WORD)) begin
                    state_d    = ST_HALT;
                    halted_d   = 1'b1;
                    fetch_en_d = 1'b0;
                end else if (stall) begin
                    fetch_en_d = 1'b0;
                end else begin
                    pc_d       = pc_q + PC_ONE;
                    fetch_en_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                flush_d    = 1'b1;
                fetch_en_d = 1'b0;
                // A second redirect restarts the bubble window at the new target.
                if (redirect) begin
                    pc_d  = target;
                    cnt_d = FLUSH_RELOAD;
                end else if (cnt_q == 3'd0) begin
                    state_d    = ST_RUN;
                    flush_d    = 1'b0;
                    fetch_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_HALT: begin
                fetch_en_d = 1'b0;
                flush_d    = 1'b0;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            fetch_en_q <= 1'b0;
            flush_q    <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_en_q <= fetch_en_d;
            flush_q    <= flush_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc       = pc_q;
    assign fetch_en = fetch_en_q;
    assign flush    = flush_q;
    assign halted   = halted_q;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    // Counters look at the registered fetch_en, i.e. what fetch actually saw.
    always_comb begin
        fetch_count_d  = fetch_count_q;
        bubble_count_d = bubble_count_q;
        if (state_q != ST_HALT) begin
            if (fetch_en_q && (fetch_count_q != '1))
                fetch_count_d = fetch_count_q + 32'd1;
            if (!fetch_en_q && ((state_q == ST_RUN) || (state_q == ST_FLUSH))
                && (bubble_count_q != '1))
                bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign fetch_count  = fetch_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (ADDR_W=9, FLUSH_CYCLES=1).
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       do_branch;
    logic       do_jump;
    logic [8:0] target;
    logic       fetched_valid;
    logic [15:0] fetched_word;
    logic [8:0] pc;
    logic       fetch_en;
    logic       flush;
    logic       halted;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(
        .ADDR_W      (9),
        .RESET_PC    (9'h000),
        .HALT_WORD   (16'hffff),
        .FLUSH_CYCLES(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .do_branch    (do_branch),
        .do_jump      (do_jump),
        .target       (target),
        .fetched_valid(fetched_valid),
        .fetched_word (fetched_word),
        .pc           (pc),
        .fetch_en     (fetch_en),
        .flush        (flush),
        .halted       (halted)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [8:0] e_pc, input logic e_en,
                              input logic e_fl, input logic e_h);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".fetch_en"}, 32'(fetch_en), 32'(e_en));
        check({tag, ".flush"}, 32'(flush), 32'(e_fl));
        check({tag, ".halted"}, 32'(halted), 32'(e_h));
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; do_branch = 1'b0; do_jump = 1'b0;
        target = '0; fetched_valid = 1'b0; fetched_word = '0;
        #1;
        expect_out("reset", 9'h000, 0, 0, 0);
`ifdef FETCH_SEQ_PERF_EN
        check("reset.fetch_count", fetch_count, 32'd0);
        check("reset.bubble_count", bubble_count, 32'd0);
`endif
        step(); step();
        rst = 1'b1;
        expect_out("boot", 9'h000, 0, 0, 0);
        step(); expect_out("run0", 9'h000, 1, 0, 0);
        step(); expect_out("run1", 9'h001, 1, 0, 0);
        step(); expect_out("run2", 9'h002, 1, 0, 0);

        // stall for three edges at pc=2
        stall = 1'b1;
        step(); expect_out("stall1", 9'h002, 0, 0, 0);
        step(); expect_out("stall2", 9'h002, 0, 0, 0);
        step(); expect_out("stall3", 9'h002, 0, 0, 0);
        stall = 1'b0;
        step(); expect_out("resume3", 9'h003, 1, 0, 0);
        step(); expect_out("resume4", 9'h004, 1, 0, 0);

        // branch at pc=4
        do_branch = 1'b1; target = 9'h020;
        step(); expect_out("br.flush", 9'h020, 0, 1, 0);
        do_branch = 1'b0;
        step(); expect_out("br.first", 9'h020, 1, 0, 0);
        step(); expect_out("br.next", 9'h021, 1, 0, 0);

        // jump and stall together: redirect wins
        do_jump = 1'b1; stall = 1'b1; target = 9'h010;
        step(); expect_out("jmpstall.flush", 9'h010, 0, 1, 0);
        do_jump = 1'b0; stall = 1'b0;
        step(); expect_out("jmpstall.first", 9'h010, 1, 0, 0);
        step(); expect_out("jmpstall.next", 9'h011, 1, 0, 0);

        // both redirect strobes at once, target near the top for wrap
        do_branch = 1'b1; do_jump = 1'b1; target = 9'h1fe;
        step(); expect_out("wrap.flush", 9'h1fe, 0, 1, 0);
        do_branch = 1'b0; do_jump = 1'b0;
        step(); expect_out("wrap.1fe", 9'h1fe, 1, 0, 0);
        step(); expect_out("wrap.1ff", 9'h1ff, 1, 0, 0);
        step(); expect_out("wrap.000", 9'h000, 1, 0, 0);

        // redirect during FLUSH reloads pc and stays flushing
        do_branch = 1'b1; target = 9'h040;
        step(); expect_out("reflush.a", 9'h040, 0, 1, 0);
        target = 9'h050;
        step(); expect_out("reflush.b", 9'h050, 0, 1, 0);
        do_branch = 1'b0;
        step(); expect_out("reflush.first", 9'h050, 1, 0, 0);

        // halt word without fetched_valid must not halt
        fetched_word = 16'hffff; fetched_valid = 1'b0;
        step(); expect_out("nohalt", 9'h051, 1, 0, 0);
        fetched_word = 16'h0000;

        // non-halt word with valid must not halt either
        fetched_word = 16'hfffe; fetched_valid = 1'b1;
        step(); expect_out("nohalt2", 9'h052, 1, 0, 0);
        fetched_valid = 1'b0; fetched_word = 16'h0000;

        // get to pc=6 and halt there
        do_branch = 1'b1; target = 9'h006;
        step(); expect_out("to6.flush", 9'h006, 0, 1, 0);
        do_branch = 1'b0;
        step(); expect_out("to6.first", 9'h006, 1, 0, 0);
        fetched_valid = 1'b1; fetched_word = 16'hffff;
        step(); expect_out("halt", 9'h006, 0, 0, 1);
        fetched_valid = 1'b0; fetched_word = 16'h0000;
        do_branch = 1'b1; target = 9'h077; stall = 1'b1;
        step(); expect_out("halt.ign1", 9'h006, 0, 0, 1);
        step(); expect_out("halt.ign2", 9'h006, 0, 0, 1);
        do_branch = 1'b0; stall = 1'b0;

        // asynchronous reset out of HALT
        rst = 1'b0;
        #1; expect_out("rst.halt", 9'h000, 0, 0, 0);
        step();
        rst = 1'b1;
        step(); expect_out("rst.halt.run0", 9'h000, 1, 0, 0);
        step(); expect_out("rst.halt.run1", 9'h001, 1, 0, 0);

        // asynchronous reset in the middle of FLUSH
        do_jump = 1'b1; target = 9'h0a0;
        step(); expect_out("midflush", 9'h0a0, 0, 1, 0);
        do_jump = 1'b0;
        rst = 1'b0;
        #1; expect_out("rst.flush", 9'h000, 0, 0, 0);
        step();
        rst = 1'b1;
        step(); expect_out("rst.flush.run0", 9'h000, 1, 0, 0);

        // ten fetching edges, then a redirect
        for (int i = 0; i < 10; i++) step();
        expect_out("run10", 9'h00a, 1, 0, 0);
`ifdef FETCH_SEQ_PERF_EN
        check("perf.fetch10", fetch_count, 32'd10);
        check("perf.bubble0", bubble_count, 32'd0);
`endif
        do_branch = 1'b1; target = 9'h100;
        step(); expect_out("perf.flush", 9'h100, 0, 1, 0);
        do_branch = 1'b0;
        step(); expect_out("perf.first", 9'h100, 1, 0, 0);
`ifdef FETCH_SEQ_PERF_EN
        check("perf.fetch11", fetch_count, 32'd11);
        check("perf.bubble1", bubble_count, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
